pipe_latency_meter: RTL and testbench
=====================================

Name: pipe_latency_meter

Overview:
- Downstream stage for the 4-bit register pipelines (a -> b -> c, clocked on clk).
- Watches the pipeline input a and its output c, and measures the number of clock edges until a sampled input value appears at c.
- Reports the result with done/timeout pulses.
- Used on the bench to tell the 1-deep (blocking) pipeline from the 2-deep (nonblocking) one, and in-system as a latency self-check.

Parameters:
- WIDTH, 4, data width of a_in/c_in.
- MAX_LAT, 15, largest latency measured before declaring timeout (>=1).
- CW, derived localparam = $clog2(MAX_LAT+1), counter/latency width (4 for defaults).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a measurement; sampled only in IDLE.
- a_in  input  WIDTH  pipeline input (same net that drives the pipeline's a).
- c_in  input  WIDTH  pipeline output c.
- busy  output  1  high in COUNT.
- done  output  1  one-cycle pulse: match found.
- timeout  output  1  one-cycle pulse: no match within MAX_LAT.
- latency  output  CW  last measured latency; held until the next report.
- meas_cnt  output  8  number of completed measurements (done or timeout); wraps 255 -> 0.

Behaviour:
- Reset values: state=IDLE, busy=0, done=0, timeout=0, latency=0, meas_cnt=0, internal ref=0, cnt=0.
- Reset is synchronous and overrides everything, including mid-COUNT. No report pulse is issued for an aborted measurement.
- States are IDLE, COUNT and REPORT.

- IDLE:
  - On an edge with start=1, register ref<=a_in and cnt<=0.
  - If c_in==a_in at that same edge: latency<=0, done<=1, state<=REPORT (zero-latency / already-equal case).
  - Otherwise state<=COUNT.
  - start=0: stay in IDLE.
- COUNT, evaluated on each edge, with k = cnt+1:
  - If c_in==ref: latency<=k, done<=1, state<=REPORT.
  - Else if k==MAX_LAT: latency<=0, timeout<=1, state<=REPORT.
  - Else cnt<=k.
  - start is ignored in COUNT.
  - a_in changes during COUNT are ignored; only ref matters.
- REPORT:
  - done/timeout are high for exactly this one cycle.
  - meas_cnt<=meas_cnt+1 on the edge leaving REPORT.
  - State returns to IDLE unconditionally.
  - start is ignored in REPORT, so a new measurement needs start high in IDLE (minimum 2-cycle spacing after a report).
- Latency definition: the edge that samples start is edge 0. latency=k means c_in equalled ref just before edge k. For the same a_in edge sampling, a 1-register pipeline yields 1 and a 2-register pipeline yields 2.
- Match on the final edge (k==MAX_LAT and c_in==ref): done wins, latency=MAX_LAT.
- Comparison is full-width equality. X on c_in is treated as mismatch on the bench and is not an RTL concern.
- busy is combinational from state (state==COUNT). done, timeout and latency are registered.
- cnt never exceeds MAX_LAT-1, so no wrap inside COUNT is possible.

Decomposition:
- Shared package pipe_meas_pkg holds:
  - state encoding constants S_IDLE=2'd0, S_COUNT=2'd1, S_REPORT=2'd2;
  - default WIDTH/MAX_LAT values;
  - a clog2 helper for CW.
- No sub-module is needed. The FSM, counter and compare fit in one module of about 150 lines.

Test Plan:
- Pipeline depth 2, clk period 100ns. a=4'h3 settled to c; set a=4'h7 and pulse start at the same edge -> done pulse two cycles later, latency=2, meas_cnt=1.
- Pipeline depth 1, same stimulus with a=4'hf -> done after one edge, latency=1.
- c_in tied to 4'h0, start with a_in=4'ha, MAX_LAT=15 -> timeout on the 15th edge after start, latency=0, done never asserted, meas_cnt increments.
- a_in==c_in==4'h2 when start sampled -> done next cycle with latency=0, busy never high.
- rst asserted at cnt=1 during COUNT -> next cycle IDLE, all outputs 0, no done/timeout. start held high through COUNT and REPORT is ignored until IDLE.
- 256 back-to-back measurements -> meas_cnt wraps to 0. Match exactly at k==MAX_LAT -> done with latency=15, not timeout.

Source files
------------

// File: rtl/pipe_meas_pkg.sv
// Shared definitions for the pipeline latency meter: FSM encoding,
// default sizing and the counter-width helper.
package pipe_meas_pkg;

    localparam int DEF_WIDTH   = 4;
    localparam int DEF_MAX_LAT = 15;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_COUNT  = 2'd1,
        S_REPORT = 2'd2
    } state_t;

    // Bits needed to hold values 0 .. value-1 (at least one bit).
    function automatic int clog2(input int value);
        int bits;
        int v;
        bits = 0;
        v    = value - 1;
        while (v > 0) begin
            bits++;
            v = v >> 1;
        end
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage

// File: rtl/pipe_latency_meter.sv
// Measures how many clock edges a value sampled at the pipeline input takes
// to reach the pipeline output, reporting done/timeout pulses.
module pipe_latency_meter
    import pipe_meas_pkg::*;
#(
    parameter  int WIDTH   = DEF_WIDTH,
    parameter  int MAX_LAT = DEF_MAX_LAT,
    localparam int CW      = clog2(MAX_LAT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] c_in,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CW-1:0]    latency,
    output logic [7:0]       meas_cnt
);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] ref_q;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    k;
    logic             hit_now;
    logic             hit_ref;
    logic             last_edge;

    assign k         = cnt_q + CW'(1);
    assign hit_now   = (c_in == a_in);
    assign hit_ref   = (c_in == ref_q);
    assign last_edge = (k == CW'(MAX_LAT));

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would collapse register chains.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = hit_now ? S_REPORT : S_COUNT;
                end
            end
            S_COUNT: begin
                if (hit_ref || last_edge) begin
                    state_d = S_REPORT;
                end
            end
            S_REPORT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == S_COUNT);
    end

    // Datapath: reference capture, edge counter and registered report.
    always_ff @(posedge clk) begin
        if (rst) begin
            ref_q    <= '0;
            cnt_q    <= '0;
            latency  <= '0;
            done     <= 1'b0;
            timeout  <= 1'b0;
            meas_cnt <= 8'd0;
        end else begin
            done    <= 1'b0;
            timeout <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        ref_q <= a_in;
                        cnt_q <= '0;
                        if (hit_now) begin
                            latency <= '0;
                            done    <= 1'b1;
                        end
                    end
                end
                S_COUNT: begin
                    // A match on the final edge still counts as done.
                    if (hit_ref) begin
                        latency <= k;
                        done    <= 1'b1;
                    end else if (last_edge) begin
                        latency <= '0;
                        timeout <= 1'b1;
                    end else begin
                        cnt_q <= k;
                    end
                end
                S_REPORT: meas_cnt <= meas_cnt + 8'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_latency_meter.sv
// Scoreboard bench for pipe_latency_meter driving a modelled 1/2-deep
// pipeline (or a tied c value) and checking every report pulse.
module tb_pipe_latency_meter;

    localparam int WIDTH   = 4;
    localparam int MAX_LAT = 15;
    localparam int CW      = 4;

    typedef struct {
        bit         is_done;
        int         lat;
        int         cyc;
        logic [7:0] meas;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] c_tie;
    logic [WIDTH-1:0] c_in;
    int               c_sel;
    logic             busy;
    logic             done;
    logic             timeout;
    logic [CW-1:0]    latency;
    logic [7:0]       meas_cnt;

    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_meas = 8'd0;
    exp_t       sb[$];

    always #50 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        b   <= a;
        c   <= b;
    end

    assign c_in = (c_sel == 0) ? c_tie : (c_sel == 1) ? b : c;

    pipe_latency_meter #(.WIDTH(WIDTH), .MAX_LAT(MAX_LAT)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a_in     (a),
        .c_in     (c_in),
        .busy     (busy),
        .done     (done),
        .timeout  (timeout),
        .latency  (latency),
        .meas_cnt (meas_cnt)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at the negedge where start is raised: edge 0 is the next posedge.
    task automatic push_exp(input bit is_done, input int lat, input int offset);
        exp_t e;
        e.is_done = is_done;
        e.lat     = lat;
        e.cyc     = cyc + 1 + offset;
        e.meas    = exp_meas;
        exp_meas  = exp_meas + 8'd1;
        sb.push_back(e);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("report_arrived", (sb.size() == 0) ? 1 : 0, 1);
        sb.delete();
    endtask

    task automatic settle(input int sel, input logic [WIDTH-1:0] a_val);
        c_sel = sel;
        a     = a_val;
        repeat (3) @(negedge clk);
    endtask

    task automatic measure(input logic [WIDTH-1:0] a_new, input bit exp_done,
                           input int exp_lat);
        a     = a_new;
        start = 1'b1;
        push_exp(exp_done, exp_lat, exp_done ? exp_lat : MAX_LAT);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", int'(busy), (exp_done && exp_lat == 0) ? 0 : 1);
        drain(MAX_LAT + 5);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: every report pulse must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done || timeout) begin
                if (sb.size() == 0) begin
                    check("unexpected_pulse", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("done", int'(done), int'(e.is_done));
                    check("timeout", int'(timeout), int'(!e.is_done));
                    check("latency", int'(latency), e.lat);
                    check("meas_cnt", int'(meas_cnt), int'(e.meas));
                    check("report_edge", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        c_tie = '0;
        c_sel = 2;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_timeout", int'(timeout), 0);
        check("rst_latency", int'(latency), 0);
        check("rst_meas_cnt", int'(meas_cnt), 0);
        rst = 1'b0;

        // Two-deep pipeline, one-deep pipeline, timeout, zero latency.
        settle(2, 4'h3);
        measure(4'h7, 1'b1, 2);
        settle(1, 4'h0);
        measure(4'hf, 1'b1, 1);
        c_tie = 4'h0;
        settle(0, 4'ha);
        measure(4'ha, 1'b0, 0);
        settle(2, 4'h2);
        measure(4'h2, 1'b1, 0);

        // start held high: only re-sampled once back in IDLE.
        settle(2, 4'h3);
        a     = 4'h7;
        start = 1'b1;
        push_exp(1'b1, 2, 2);
        push_exp(1'b1, 0, 4);
        @(negedge clk);
        check("held_busy", int'(busy), 1);
        repeat (4) @(negedge clk);
        start = 1'b0;
        drain(10);
        repeat (2) @(negedge clk);

        // Reset while counting aborts without a report.
        c_tie = 4'h0;
        settle(0, 4'h5);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_timeout", int'(timeout), 0);
        check("abort_latency", int'(latency), 0);
        check("abort_meas_cnt", int'(meas_cnt), 0);
        rst      = 1'b0;
        exp_meas = 8'd0;
        repeat (20) @(negedge clk);
        check("abort_idle", int'(busy), 0);

        // 256 back-to-back zero-latency measurements wrap meas_cnt.
        settle(2, 4'h2);
        start = 1'b1;
        for (int i = 0; i < 256; i++) begin
            push_exp(1'b1, 0, 2 * i);
        end
        repeat (511) @(negedge clk);
        start = 1'b0;
        drain(10);
        @(negedge clk);
        check("wrap_meas_cnt", int'(meas_cnt), 0);

        // Match on the very last edge: done wins with latency MAX_LAT.
        c_tie = 4'h0;
        settle(0, 4'h9);
        start = 1'b1;
        push_exp(1'b1, MAX_LAT, MAX_LAT);
        @(negedge clk);
        start = 1'b0;
        repeat (MAX_LAT - 1) @(negedge clk);
        c_tie = 4'h9;
        drain(10);
        repeat (2) @(negedge clk);
        check("final_meas_cnt", int'(meas_cnt), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
